// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared constants for the logic unit arbiter
package logic_unit_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  localparam logic [OPW-1:0] OP_AND   = 3'b000;
  localparam logic [OPW-1:0] OP_OR    = 3'b001;
  localparam logic [OPW-1:0] OP_XOR   = 3'b010;
  localparam logic [OPW-1:0] OP_XNOR  = 3'b011;
  localparam logic [OPW-1:0] OP_NAND  = 3'b100;
  localparam logic [OPW-1:0] OP_NOR   = 3'b101;
  localparam logic [OPW-1:0] OP_NOTA  = 3'b110;
  localparam logic [OPW-1:0] OP_PASSA = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/bitwise_unit.sv
// rtl/bitwise_unit.sv - combinational bitwise op select for the shared logic unit
module bitwise_unit
  import logic_unit_pkg::*;
#(
  parameter int W = 32
) (
  output logic [W-1:0]   Result,
  input  logic [OPW-1:0] Op,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B
);

  logic [W-1:0] and_v;
  logic [W-1:0] or_v;
  logic [W-1:0] xor_v;

  assign and_v = A & B;
  assign or_v  = A | B;
  assign xor_v = A ^ B;

  // Inverting ops reuse the base gate outputs rather than separate gates.
  always_comb begin
    Result = '0;
    case (Op)
      OP_AND:   Result = and_v;
      OP_OR:    Result = or_v;
      OP_XOR:   Result = xor_v;
      OP_XNOR:  Result = ~xor_v;
      OP_NAND:  Result = ~and_v;
      OP_NOR:   Result = ~or_v;
      OP_NOTA:  Result = ~A;
      OP_PASSA: Result = A;
      default:  Result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin share of one bitwise logic unit between two requesters
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [OPW-1:0]   Req0_Op,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [OPW-1:0]   Req1_Op,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  output logic             Rsp_Valid,
  input  logic             Rsp_Ready,
  output logic             Rsp_Id,
  output logic [WIDTH-1:0] Rsp_Result,
  output logic             Rsp_Zero,
  output logic             Busy
);

  state_t           state, state_next;
  logic             ptr;
  logic             grant;
  logic             can_accept;
  logic             hs;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_result;

  // A lone requester wins outright; the pointer only breaks ties (and idles).
  always_comb begin
    grant = ptr;
    if (Req0_Valid && !Req1_Valid) grant = REQ0;
    if (Req1_Valid && !Req0_Valid) grant = REQ1;
  end

  assign can_accept = (state == ST_EMPTY) || Rsp_Ready;
  assign Req0_Ready = can_accept && (grant == REQ0);
  assign Req1_Ready = can_accept && (grant == REQ1);
  assign hs         = (Req0_Valid && Req0_Ready) || (Req1_Valid && Req1_Ready);

  assign sel_op = (grant == REQ1) ? Req1_Op : Req0_Op;
  assign sel_a  = (grant == REQ1) ? Req1_A  : Req0_A;
  assign sel_b  = (grant == REQ1) ? Req1_B  : Req0_B;

  bitwise_unit #(.W(WIDTH)) u_bitwise (
    .Result (op_result),
    .Op     (sel_op),
    .A      (sel_a),
    .B      (sel_b)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (hs)                                   state_next = ST_FULL;
    else if (state == ST_FULL && Rsp_Ready)   state_next = ST_EMPTY;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr        <= REQ0;
      Rsp_Id     <= REQ0;
      Rsp_Result <= '0;
      Rsp_Zero   <= 1'b1;
    end else if (hs) begin
      ptr        <= ~grant;
      Rsp_Id     <= grant;
      Rsp_Result <= op_result;
      Rsp_Zero   <= ~|op_result;
    end
  end

  assign Rsp_Valid = (state == ST_FULL);
  assign Busy      = Rsp_Valid;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - directed self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req0_Valid, Req0_Ready;
  logic [2:0]  Req0_Op;
  logic [31:0] Req0_A, Req0_B;
  logic        Req1_Valid, Req1_Ready;
  logic [2:0]  Req1_Op;
  logic [31:0] Req1_A, Req1_B;
  logic        Rsp_Valid, Rsp_Ready, Rsp_Id, Rsp_Zero, Busy;
  logic [31:0] Rsp_Result;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sweep_exp [8];
  logic [31:0] lone_a    [4];
  logic [31:0] lone_exp  [4];

  always #5 Clk = ~Clk;

  logic_unit_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Req0_Valid (Req0_Valid),
    .Req0_Ready (Req0_Ready),
    .Req0_Op    (Req0_Op),
    .Req0_A     (Req0_A),
    .Req0_B     (Req0_B),
    .Req1_Valid (Req1_Valid),
    .Req1_Ready (Req1_Ready),
    .Req1_Op    (Req1_Op),
    .Req1_A     (Req1_A),
    .Req1_B     (Req1_B),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Id     (Rsp_Id),
    .Rsp_Result (Rsp_Result),
    .Rsp_Zero   (Rsp_Zero),
    .Busy       (Busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] res, input logic z);
    chk({tag, "_valid"}, {31'd0, Rsp_Valid}, {31'd0, v});
    chk({tag, "_busy"},  {31'd0, Busy},      {31'd0, v});
    chk({tag, "_id"},    {31'd0, Rsp_Id},    {31'd0, id});
    chk({tag, "_res"},   Rsp_Result,         res);
    chk({tag, "_zero"},  {31'd0, Rsp_Zero},  {31'd0, z});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, {31'd0, Req0_Ready}, {31'd0, r0});
    chk({tag, "_rdy1"}, {31'd0, Req1_Ready}, {31'd0, r1});
  endtask

  initial begin
    sweep_exp = '{32'h05050505, 32'hAFAFAFAF, 32'hAAAAAAAA, 32'h55555555,
                  32'hFAFAFAFA, 32'h50505050, 32'h5A5A5A5A, 32'hA5A5A5A5};
    lone_a    = '{32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'hF0F0F0F0};
    lone_exp  = '{32'hFFFFFFFF, 32'h00000000, 32'hEDCBA987, 32'h0F0F0F0F};

    Rst_n = 1'b0; Rsp_Ready = 1'b0;
    Req0_Valid = 1'b0; Req0_Op = 3'd0; Req0_A = '0; Req0_B = '0;
    Req1_Valid = 1'b0; Req1_Op = 3'd0; Req1_A = '0; Req1_B = '0;
    tick(); tick();
    chk_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b1);
    Rst_n = 1'b1;

    // single XNOR op from Req0
    Req0_Valid = 1'b1; Req0_Op = 3'b011; Req0_A = 32'hFFFF0000; Req0_B = 32'hFF00FF00;
    Rsp_Ready = 1'b1;
    #1 chk_rdy("single_pre", 1'b1, 1'b0);
    tick();
    Req0_Valid = 1'b0;
    chk_rsp("single", 1'b1, 1'b0, 32'hFF0000FF, 1'b0);

    // Req1 loads while draining, then stall and reset mid-FULL
    Req1_Valid = 1'b1; Req1_Op = 3'b111; Req1_A = 32'h12345678; Req1_B = 32'h0;
    #1 chk_rdy("drain_reload_pre", 1'b0, 1'b1);
    tick();
    Req1_Valid = 1'b0; Rsp_Ready = 1'b0;
    chk_rsp("drain_reload", 1'b1, 1'b1, 32'h12345678, 1'b0);
    tick();
    chk_rsp("stall", 1'b1, 1'b1, 32'h12345678, 1'b0);
    #2 Rst_n = 1'b0;
    #1 chk_rsp("async_reset", 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    Rst_n = 1'b1;

    // contention: grants alternate starting at Req0
    Req0_Valid = 1'b1; Req0_Op = 3'b000; Req0_A = 32'h0F0F0F0F; Req0_B = 32'hF0F0F0F0;
    Req1_Valid = 1'b1; Req1_Op = 3'b001; Req1_A = 32'h00000001; Req1_B = 32'h00000002;
    Rsp_Ready = 1'b1;
    #1 chk_rdy("cont_pre", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk_rsp($sformatf("cont%0d", i), 1'b1, 1'b0, 32'h00000000, 1'b1);
        chk_rdy($sformatf("cont%0d", i), 1'b0, 1'b1);
      end else begin
        chk_rsp($sformatf("cont%0d", i), 1'b1, 1'b1, 32'h00000003, 1'b0);
        chk_rdy($sformatf("cont%0d", i), 1'b1, 1'b0);
      end
    end

    // backpressure: three stalled cycles, outputs held
    Rsp_Ready = 1'b0;
    Req1_Op = 3'b010; Req1_A = 32'h000000FF; Req1_B = 32'h0000000F;
    for (int i = 0; i < 3; i++) begin
      #1 chk_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      tick();
      chk_rsp($sformatf("bp%0d", i), 1'b1, 1'b1, 32'h00000003, 1'b0);
    end
    Req0_Valid = 1'b0; Rsp_Ready = 1'b1;
    #1 chk_rdy("bp_release_pre", 1'b0, 1'b1);
    tick();
    Req1_Valid = 1'b0;
    chk_rsp("bp_release", 1'b1, 1'b1, 32'h000000F0, 1'b0);

    // opcode sweep on Req0
    Req0_Valid = 1'b1; Req0_A = 32'hA5A5A5A5; Req0_B = 32'h0F0F0F0F;
    for (int op = 0; op < 8; op++) begin
      Req0_Op = 3'(op);
      tick();
      chk_rsp($sformatf("sweep_op%0d", op), 1'b1, 1'b0, sweep_exp[op], 1'b0);
    end
    Req0_Valid = 1'b0;

    // lone Req1: granted each cycle whatever the pointer says
    Req1_Valid = 1'b1; Req1_Op = 3'b110; Req1_B = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      Req1_A = lone_a[i];
      #1 chk_rdy($sformatf("lone%0d_pre", i), 1'b0, 1'b1);
      tick();
      chk_rsp($sformatf("lone%0d", i), 1'b1, 1'b1, lone_exp[i], (lone_exp[i] == 32'h0));
    end
    Req1_Valid = 1'b0;

    // drain to EMPTY; result registers keep their last value
    tick();
    chk({"drain", "_valid"}, {31'd0, Rsp_Valid}, 32'd0);
    chk({"drain", "_busy"},  {31'd0, Busy},      32'd0);
    #1 chk_rdy("idle", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one 32-bit bitwise logic unit between two requesters: the integer-execute port (Req0) and the branch/compare helper port (Req1).
- Round-robin arbitration with a valid/ready request handshake per requester.
- Computes the selected bitwise op and registers the result with the requester ID.
- Presents the result on a single valid/ready response channel.
- Sits in the datapath between issue logic and the bitwise gate modules.

Parameters:
WIDTH, 32, operand/result width
OPW, 3, opcode width

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Req0_Valid  input  1  requester 0 has an operation
Req0_Ready  output  1  requester 0 operation accepted this cycle
Req0_Op  input  OPW  requester 0 opcode
Req0_A  input  WIDTH  requester 0 operand A
Req0_B  input  WIDTH  requester 0 operand B
Req1_Valid, Req1_Ready, Req1_Op, Req1_A, Req1_B: same widths and meanings as Req0, for requester 1
Rsp_Valid  output  1  result register holds an unconsumed result
Rsp_Ready  input  1  consumer accepts the result
Rsp_Id  output  1  requester that owns the result (0/1)
Rsp_Result  output  WIDTH  registered result
Rsp_Zero  output  1  Rsp_Result == 0
Busy  output  1  equals Rsp_Valid

Behaviour:
- Reset (Rst_n low, asynchronous, any time including mid-transaction): state=EMPTY, Rsp_Valid=0, Rsp_Id=0, Rsp_Result=0, Rsp_Zero=1, Busy=0, priority pointer=0 (Req0 favoured). Any pending result is discarded.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR
  - 100 NAND, 101 NOR, 110 NOT A (B ignored), 111 PASS A
  - All ops are bitwise on WIDTH bits; no carries, no flags other than zero.
- States:
  - EMPTY: result register invalid.
  - FULL: Rsp_Valid=1.
- Accept condition: can_accept = (state==EMPTY) | (state==FULL & Rsp_Ready).
- Grant logic (combinational):
  - If only one Valid is high, grant that requester.
  - If both are high, grant the priority-pointer requester.
  - ReqN_Ready = can_accept & grant==N.
  - Never both Ready high in one cycle. Ready may be high with Valid low only for the non-winning case; no transfer occurs without Valid.
- On a request handshake (Valid & Ready):
  - Next edge: Rsp_Result <= op(A,B), Rsp_Id <= N, Rsp_Zero <= (op result==0), state <= FULL.
  - Priority pointer <= other requester (1-N).
- FULL & Rsp_Ready & no new handshake: state <= EMPTY, Rsp_Valid drops next cycle. Result and ID registers hold their old value (don't care).
- FULL & Rsp_Ready & new handshake in the same cycle: state stays FULL, register reloads. This gives back-to-back throughput of 1 op/cycle.
- FULL & !Rsp_Ready: both Ready low; Rsp_Result/Rsp_Id/Rsp_Zero held stable.
- Latency: request handshake at edge k, Rsp_Valid high after edge k (visible cycle k+1).
- Pointer does not change without a handshake; a lone requester is granted regardless of the pointer.
- Requester inputs are sampled only on the handshake cycle; no stability assumption is required of them.

Decomposition:
- Package logic_unit_pkg holds:
  - opcode localparams OP_AND..OP_PASSA
  - state encoding ST_EMPTY / ST_FULL
  - requester ID constants REQ0 / REQ1
- Sub-module bitwise_unit(Result, Op, A, B): purely combinational op select. It is built from the team's existing 32-bit AND/OR/XOR/XNOR gate modules plus inversion.
- The arbiter holds only grant, pointer, state and result registers.

Test Plan:
- Reset: drive Rst_n=0 mid-FULL with Rsp_Ready=0 -> Rsp_Valid=0, Rsp_Result=0, Rsp_Zero=1 immediately (asynchronous); first grant after release goes to Req0 when both are valid.
- Single op: Req0 XNOR A=0xFFFF0000, B=0xFF00FF00, Rsp_Ready=1 -> next cycle Rsp_Valid=1, Rsp_Id=0, Rsp_Result=0xFF0000FF, Rsp_Zero=0.
- Contention: both valid continuously, Req0 AND 0x0F0F0F0F/0xF0F0F0F0, Req1 OR 0x1/0x2, Rsp_Ready=1 -> grants alternate 0,1,0,1; results 0x00000000 (Zero=1), 0x00000003, ...; one result per cycle.
- Backpressure: Rsp_Ready=0 for 3 cycles after a result -> Req0_Ready=Req1_Ready=0, outputs held; raise Rsp_Ready with Req1 valid -> same-cycle handshake, reload with Rsp_Id=1.
- Opcode sweep: A=0xA5A5A5A5, B=0x0F0F0F0F through all 8 opcodes -> 0x05050505, 0xAFAFAFAF, 0xAAAAAAAA, 0x55555555, 0xFAFAFAFA, 0x50505050, 0x5A5A5A5A, 0xA5A5A5A5.
- Lone requester: only Req1 valid for 4 ops -> Req1 granted every cycle despite pointer favouring Req0.
